// File: rtl/branch_predictor_nbit.sv
// Direct-mapped BTB branch predictor with N-bit saturating counters, synchronous
// flush and saturating performance counters for resolved branches and mispredicts.
module branch_predictor_nbit #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ROWS   = 16,
  parameter int CTR_BITS   = 2,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] PC_f,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_uncond,
  input  logic                  upd_mispredict,
  input  logic                  flush,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int IDX_BITS = $clog2(BTB_ROWS);
  localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic                  btb_valid  [BTB_ROWS];
  logic [TAG_BITS-1:0]   btb_tag    [BTB_ROWS];
  logic [DATA_WIDTH-1:0] btb_target [BTB_ROWS];
  logic [CTR_BITS-1:0]   btb_ctr    [BTB_ROWS];
  logic                  btb_uncond [BTB_ROWS];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                f_is_br, f_hit;
  logic                u_en, u_hit, u_alloc, u_train;
  logic [CTR_BITS-1:0] ctr_next;

  // Fetch-side lookup reads the array directly: updates become visible only after the edge.
  assign f_idx   = PC_f[IDX_BITS+1:2];
  assign f_tag   = PC_f[DATA_WIDTH-1:IDX_BITS+2];
  assign f_is_br = (RD[6:0] == OP_BRANCH) || (RD[6:0] == OP_JAL);
  assign f_hit   = f_is_br && btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

  assign predict_taken = f_hit && (btb_uncond[f_idx] || btb_ctr[f_idx][CTR_BITS-1]);
  assign branch_target = predict_taken ? btb_target[f_idx] : PC_f;

  assign u_idx   = upd_pc[IDX_BITS+1:2];
  assign u_tag   = upd_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign u_en    = upd_valid && !flush;
  assign u_hit   = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
  assign u_train = u_en && u_hit;
  assign u_alloc = u_en && !u_hit && (upd_taken || upd_uncond);

  always_comb begin
    ctr_next = btb_ctr[u_idx];
    if (upd_taken) begin
      if (btb_ctr[u_idx] != CTR_MAX) ctr_next = btb_ctr[u_idx] + CTR_BITS'(1);
    end else begin
      if (btb_ctr[u_idx] != '0) ctr_next = btb_ctr[u_idx] - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ROWS; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < BTB_ROWS; i++) btb_valid[i] <= 1'b0;
    end else if (u_alloc) begin
      btb_valid[u_idx] <= 1'b1;
      btb_ctr[u_idx]   <= CTR_WEAK;
    end else if (u_train) begin
      btb_ctr[u_idx] <= ctr_next;
    end
  end

  // Payload needs no reset: a cleared valid bit masks whatever it holds.
  always_ff @(posedge clk) begin
    if (u_alloc || u_train) begin
      if (u_alloc) btb_tag[u_idx] <= u_tag;
      if (u_alloc || upd_taken) btb_target[u_idx] <= upd_target;
      btb_uncond[u_idx] <= upd_uncond;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      if (perf_branches != '1) perf_branches <= perf_branches + PERF_WIDTH'(1);
      if (upd_mispredict && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_nbit.sv
// Scoreboard bench for branch_predictor_nbit (16 rows, 2-bit counters, 4-bit perf counters).
module tb_branch_predictor_nbit;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD, PC_f, branch_target, upd_pc, upd_target;
  logic        predict_taken, upd_valid, upd_taken, upd_uncond, upd_mispredict, flush;
  logic [3:0]  perf_branches, perf_mispredicts;

  branch_predictor_nbit #(.DATA_WIDTH(32), .BTB_ROWS(16), .CTR_BITS(2), .PERF_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .RD(RD), .PC_f(PC_f),
    .predict_taken(predict_taken), .branch_target(branch_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_uncond(upd_uncond),
    .upd_mispredict(upd_mispredict), .flush(flush),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];
  logic        m_unc   [16];
  logic [3:0]  m_pb, m_pm;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'd0;
    end
    m_pb = 4'd0;
    m_pm = 4'd0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, input logic [31:0] rd,
                              output logic pt, output logic [31:0] tgt);
    int  idx;
    logic hit;
    idx = int'(pc[5:2]);
    hit = (rd[6:0] == 7'b1100011 || rd[6:0] == 7'b1101111) && m_valid[idx] && m_tag[idx] == pc[31:6];
    pt  = hit && (m_unc[idx] || m_ctr[idx][1]);
    tgt = pt ? m_tgt[idx] : pc;
  endtask

  task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic uu, input logic um,
                              input logic fl);
    int idx;
    idx = int'(upc[5:2]);
    if (uv) begin
      if (m_pb != 4'hF) m_pb = m_pb + 4'd1;
      if (um && m_pm != 4'hF) m_pm = m_pm + 4'd1;
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_valid[idx] && m_tag[idx] == upc[31:6]) begin
        if (ut) begin
          if (m_ctr[idx] != 2'd3) m_ctr[idx] = m_ctr[idx] + 2'd1;
          m_tgt[idx] = utgt;
        end else if (m_ctr[idx] != 2'd0) begin
          m_ctr[idx] = m_ctr[idx] - 2'd1;
        end
        m_unc[idx] = uu;
      end else if (ut || uu) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = upc[31:6];
        m_tgt[idx]   = utgt;
        m_ctr[idx]   = 2'd2;
        m_unc[idx]   = uu;
      end
    end
  endtask

  // Called at posedge+1: drive, check the combinational lookup, then cross one edge.
  task automatic step(input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic uu, input logic um, input logic fl,
                      input logic [31:0] pc, input logic [31:0] rd, input int want_pt);
    exp_t        e;
    logic        pt;
    logic [31:0] tg;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_uncond = uu; upd_mispredict = um; flush = fl; PC_f = pc; RD = rd;
    model_lookup(pc, rd, pt, tg);
    e.pt = pt; e.tgt = tg;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check_eq("pred_taken", 64'(predict_taken), 64'(e.pt));
    check_eq("br_target", 64'(branch_target), 64'(e.tgt));
    if (want_pt >= 0) check_eq("plan_taken", 64'(predict_taken), 64'(want_pt[0]));
    @(posedge clk);
    model_update(uv, upc, ut, utgt, uu, um, fl);
    #1;
    check_eq("perf_branches", 64'(perf_branches), 64'(m_pb));
    check_eq("perf_mispredicts", 64'(perf_mispredicts), 64'(m_pm));
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] rd, input int want_pt);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pc, rd, want_pt);
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic uu, input logic [31:0] pc, input int want_pt);
    step(1'b1, upc, ut, utgt, uu, 1'b0, 1'b0, pc, BEQ, want_pt);
  endtask

  initial begin
    rst = 1'b1; RD = '0; PC_f = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
    upd_target = '0; upd_uncond = 0; upd_mispredict = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_perf_br", 64'(perf_branches), 64'd0);
    check_eq("rst_perf_mp", 64'(perf_mispredicts), 64'd0);
    look(32'h40, JAL, 0);
    check_eq("rst_jal_target", 64'(branch_target), 64'h40);

    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 0);
    look(32'h40, BEQ, 1);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1);
    upd(32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1);
    upd(32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1);
    look(32'h40, BEQ, 0);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 0);
    look(32'h40, BEQ, 1);

    upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h440, 0);
    look(32'h40, BEQ, 0);
    look(32'h440, BEQ, 1);
    look(32'h440, ADDI, 0);

    upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h80, 0);
    look(32'h80, JAL, 1);

    upd(32'h100, 1'b1, 32'h500, 1'b1, 32'h100, 0);
    upd(32'h100, 1'b0, 32'h0,   1'b1, 32'h100, 1);
    upd(32'h100, 1'b0, 32'h0,   1'b1, 32'h100, 1);
    look(32'h100, JAL, 1);

    step(1'b1, 32'hC0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'hC0, JAL, 0);
    look(32'hC0, JAL, 0);
    look(32'h80, BEQ, 0);
    look(32'h440, BEQ, 0);

    for (int i = 0; i < 20; i++)
      step(1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000, BEQ, 0);
    check_eq("sat_perf_br", 64'(perf_branches), 64'hF);
    check_eq("sat_perf_mp", 64'(perf_mispredicts), 64'hF);

    upd(32'h440, 1'b1, 32'h600, 1'b0, 32'h440, 0);
    upd_valid = 1'b0; PC_f = 32'h440; RD = BEQ;
    #1 check_eq("pre_rst_hit", 64'(predict_taken), 64'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_perf_br", 64'(perf_branches), 64'd0);
    check_eq("async_perf_mp", 64'(perf_mispredicts), 64'd0);
    check_eq("async_pred", 64'(predict_taken), 64'd0);
    check_eq("async_target", 64'(branch_target), 64'h440);
    @(posedge clk);
    #1 rst = 1'b0;
    look(32'h440, BEQ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_nbit.md
Name: branch_predictor_nbit

Overview:
- Parametrised successor to the 1-bit dynamic branch predictor.
- Direct-mapped BTB with a configurable number of rows and N-bit saturating counters per entry; N=2 is the classic 2-bit scheme.
- Fetch stage does a same-cycle combinational lookup. Execute stage writes resolved outcomes through a dedicated update port.
- Adds a synchronous BTB flush and two saturating performance counters (resolved branches, mispredicts).

Parameters:
- DATA_WIDTH, 32, PC/instruction width.
- BTB_ROWS, 16, BTB entries; power of two, ≥2. IDX_BITS = log2(BTB_ROWS).
- CTR_BITS, 2, saturating counter width, 1..4. CTR_BITS=1 reproduces 1-bit behaviour.
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RD  in  DATA_WIDTH  instruction fetched at PC_f.
- PC_f  in  DATA_WIDTH  fetch PC.
- predict_taken  out  1  fetch should redirect.
- branch_target  out  DATA_WIDTH  predicted target; PC_f when not taken.
- upd_valid  in  1  execute-stage resolved branch/JAL this cycle.
- upd_pc  in  DATA_WIDTH  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  DATA_WIDTH  actual taken target.
- upd_uncond  in  1  resolved instruction is JAL.
- upd_mispredict  in  1  execute detected a direction or target mismatch; qualified by upd_valid.
- flush  in  1  synchronous invalidate of all BTB entries.
- perf_branches  out  PERF_WIDTH  count of upd_valid cycles.
- perf_mispredicts  out  PERF_WIDTH  count of upd_valid & upd_mispredict cycles.

Behaviour:
- Indexing:
  - Index = PC[IDX_BITS+1:2].
  - Tag = PC[DATA_WIDTH-1:IDX_BITS+2].
  - The same function applies to PC_f (lookup) and upd_pc (update).
- Entry contents: valid, tag, target, ctr[CTR_BITS-1:0], uncond.
- Lookup (combinational, zero latency):
  - Hit = RD[6:0] ∈ {1100011, 1101111} AND entry valid AND tag match.
  - predict_taken = hit AND (uncond OR ctr MSB = 1).
  - branch_target = entry target when predict_taken, else PC_f.
  - Any other opcode gives predict_taken=0 and branch_target=PC_f.
- Update (rising edge, when upd_valid=1 and flush=0):
  - Hit at upd_pc:
    - Taken: ctr = min(ctr+1, 2^CTR_BITS−1). Not taken: ctr = max(ctr−1, 0).
    - Target overwritten with upd_target when upd_taken=1.
    - uncond overwritten with upd_uncond.
  - Miss, and upd_taken=1 or upd_uncond=1 (allocate, replacing any conflicting entry):
    - valid=1, tag and target from upd_pc/upd_target, uncond=upd_uncond.
    - ctr = 2^(CTR_BITS−1), i.e. weakly taken.
  - Miss with not-taken conditional branch: no allocation, no state change.
- Update is visible to lookup the cycle after the edge. A same-cycle lookup of the index being updated returns the old contents; no bypass.
- flush=1:
  - All valid bits cleared at the next edge.
  - An update in the same cycle is discarded.
  - Perf counters are still updated.
- Perf counters:
  - perf_branches increments on upd_valid.
  - perf_mispredicts increments on upd_valid & upd_mispredict.
  - Both saturate at all-ones and never wrap.
- Reset (async, immediate on rst rise):
  - All valid=0, all ctr=0, both perf counters=0.
  - predict_taken=0 and branch_target=PC_f, since no entry can hit.
  - tag, target and uncond need no reset.
  - Reset mid-update discards the update.

Test Plan:
- Reset, then JAL (RD[6:0]=1101111) at PC_f=0x40 → predict_taken=0, branch_target=0x40. perf_branches=0, perf_mispredicts=0.
- Update upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_uncond=0, then beq at PC_f=0x40 next cycle → predict_taken=1, branch_target=0x100 (ctr=2).
- Same entry (CTR_BITS=2):
  - Taken×3 → ctr saturates at 3.
  - Then not-taken×2 → ctr=1, lookup predict_taken=0.
  - Then one more taken → ctr=2, predict_taken=1.
- Alias: PC 0x40 allocated, then taken update at 0x440 with BTB_ROWS=16 → same index, new tag. Lookup at 0x40 misses (predict_taken=0); lookup at 0x440 hits.
- Simultaneous update and lookup of PC 0x80 in one cycle → lookup shows old (miss) result, next cycle shows hit. flush with upd_valid → entry not allocated, perf_branches still +1.
- PERF_WIDTH=4 with 20 cycles of upd_valid & upd_mispredict → both counters hold 15. Async rst pulse mid-cycle → both 0 immediately.
